// File: rtl/rgmii_rx.sv
// rtl/rgmii_rx.sv - RGMII receive MAC: preamble/SFD detect, header parse, dest filter,
// payload streaming with FCS stripped through a 5-byte delay line, and FCS/length/PHY status.
module rgmii_rx #(
  parameter logic [47:0] MAC_ADDR    = 48'h0,
  parameter bit          PROMISCUOUS = 1'b0,
  parameter int          MAX_FRAME   = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rxd_lo,
  input  logic [3:0]  rxd_hi,
  input  logic        rx_dv,
  input  logic        rx_ctl_fall,
  output logic        payload_valid,
  output logic [7:0]  payload_data,
  output logic        payload_last,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_phy,
  output logic [47:0] mac_dest,
  output logic [47:0] mac_src,
  output logic [15:0] ethertype
);

  typedef enum logic [2:0] {S_DROP, S_IDLE, S_PRE, S_HDR, S_PAY} state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME);
  localparam logic [15:0] MIN_LEN     = 16'd64;

  // MSB-first register fed with data bits LSB first, matching Ethernet wire order.
  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  state_t      state;
  logic [15:0] byte_cnt;
  logic [31:0] crc;
  logic [47:0] dest_sh;
  logic [47:0] src_sh;
  logic [7:0]  type_sh;
  logic [39:0] dline;
  logic [2:0]  dl_cnt;
  logic        phy_err;
  logic        over;

  logic [7:0]  rx_byte;
  logic        rx_er;
  logic [15:0] cnt_inc;
  logic [47:0] dest_next;
  logic        dest_hit;
  logic        too_long;
  logic        crc_bad;
  logic        len_bad;

  assign rx_byte   = {rxd_hi, rxd_lo};
  assign rx_er     = rx_dv ^ rx_ctl_fall;
  assign cnt_inc   = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
  assign dest_next = {dest_sh[39:0], rx_byte};
  assign dest_hit  = (dest_next == MAC_ADDR) || (dest_next == 48'hFFFF_FFFF_FFFF) || PROMISCUOUS;
  assign too_long  = cnt_inc > MAX_LEN;
  assign crc_bad   = crc != CRC_RESIDUE;
  assign len_bad   = (byte_cnt < MIN_LEN) || over;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_DROP;
      byte_cnt      <= '0;
      crc           <= '1;
      dest_sh       <= '0;
      src_sh        <= '0;
      type_sh       <= '0;
      dline         <= '0;
      dl_cnt        <= '0;
      phy_err       <= 1'b0;
      over          <= 1'b0;
      payload_valid <= 1'b0;
      payload_data  <= '0;
      payload_last  <= 1'b0;
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      err_crc       <= 1'b0;
      err_len       <= 1'b0;
      err_phy       <= 1'b0;
      mac_dest      <= '0;
      mac_src       <= '0;
      ethertype     <= '0;
    end else begin
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      err_crc       <= 1'b0;
      err_len       <= 1'b0;
      err_phy       <= 1'b0;
      case (state)
        S_DROP: begin
          if (!rx_dv) state <= S_IDLE;
        end
        S_IDLE: begin
          if (rx_dv) state <= (rx_byte == 8'h55) ? S_PRE : S_DROP;
        end
        S_PRE: begin
          if (!rx_dv) begin
            state <= S_DROP;
          end else if (rx_byte == 8'hD5) begin
            state    <= S_HDR;
            byte_cnt <= '0;
            crc      <= '1;
            dl_cnt   <= '0;
            phy_err  <= 1'b0;
            over     <= 1'b0;
          end else if (rx_byte != 8'h55) begin
            state <= S_DROP;
          end
        end
        S_HDR, S_PAY: begin
          if (!rx_dv) begin
            frame_done <= 1'b1;
            err_crc    <= crc_bad;
            err_len    <= len_bad;
            err_phy    <= phy_err;
            frame_ok   <= !(crc_bad || len_bad || phy_err);
            // The oldest of five buffered bytes is the last payload byte; the other four are FCS.
            if (state == S_PAY && dl_cnt == 3'd5 && !over) begin
              payload_valid <= 1'b1;
              payload_last  <= 1'b1;
              payload_data  <= dline[39:32];
            end
            state <= S_IDLE;
          end else begin
            byte_cnt <= cnt_inc;
            if (rx_er) phy_err <= 1'b1;
            if (too_long) begin
              over <= 1'b1;
            end else begin
              crc <= crc32_step(crc, rx_byte);
              if (state == S_HDR) begin
                if (byte_cnt < 16'd6)       dest_sh <= dest_next;
                else if (byte_cnt < 16'd12) src_sh  <= {src_sh[39:0], rx_byte};
                else                        type_sh <= rx_byte;
                if (byte_cnt == 16'd5 && !dest_hit) state <= S_DROP;
                if (byte_cnt == 16'd13) begin
                  mac_dest  <= dest_sh;
                  mac_src   <= src_sh;
                  ethertype <= {type_sh, rx_byte};
                  state     <= S_PAY;
                end
              end else begin
                if (dl_cnt == 3'd5) begin
                  payload_valid <= 1'b1;
                  payload_data  <= dline[39:32];
                end else begin
                  dl_cnt <= dl_cnt + 3'd1;
                end
                dline <= {dline[31:0], rx_byte};
              end
            end
          end
        end
        default: state <= S_DROP;
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_rx.sv
// tb/tb_rgmii_rx.sv - directed bench for rgmii_rx with reference FCS generation and an output monitor.
module tb_rgmii_rx;

  typedef logic [7:0] bq_t[$];

  localparam logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC_MAC = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rxd_lo = '0;
  logic [3:0]  rxd_hi = '0;
  logic        rx_dv = 1'b0;
  logic        rx_ctl_fall = 1'b0;
  logic        payload_valid;
  logic [7:0]  payload_data;
  logic        payload_last;
  logic        frame_done;
  logic        frame_ok;
  logic        err_crc;
  logic        err_len;
  logic        err_phy;
  logic [47:0] mac_dest;
  logic [47:0] mac_src;
  logic [15:0] ethertype;

  int errors = 0;
  int checks = 0;

  logic [7:0] pq[$];
  int   pv_cnt = 0;
  int   done_cnt = 0;
  int   last_stray = 0;
  logic d_ok, d_crc, d_len, d_phy, d_last;
  logic [7:0] d_last_data;

  rgmii_rx #(.MAC_ADDR(MY_MAC), .PROMISCUOUS(1'b0), .MAX_FRAME(1518)) dut (
    .clk(clk), .rst(rst), .rxd_lo(rxd_lo), .rxd_hi(rxd_hi), .rx_dv(rx_dv),
    .rx_ctl_fall(rx_ctl_fall), .payload_valid(payload_valid), .payload_data(payload_data),
    .payload_last(payload_last), .frame_done(frame_done), .frame_ok(frame_ok),
    .err_crc(err_crc), .err_len(err_len), .err_phy(err_phy), .mac_dest(mac_dest),
    .mac_src(mac_src), .ethertype(ethertype)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (payload_valid) begin
      pq.push_back(payload_data);
      pv_cnt++;
    end
    if (payload_last && !(frame_done && payload_valid)) last_stray++;
    if (frame_done) begin
      done_cnt++;
      d_ok = frame_ok;
      d_crc = err_crc;
      d_len = err_len;
      d_phy = err_phy;
      d_last = payload_last;
      d_last_data = payload_data;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reflected CRC-32 as on the wire; the FCS is its complement, sent LSB byte first.
  function automatic bq_t mk_frame(input logic [47:0] dst, input int plen, input int flip_idx);
    bq_t f;
    logic [31:0] c;
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(SRC_MAC[47-8*i -: 8]);
    f.push_back(8'h08);
    f.push_back(8'h00);
    for (int i = 0; i < plen; i++) f.push_back(8'(i));
    c = 32'hFFFF_FFFF;
    foreach (f[i]) begin
      c = c ^ {24'h0, f[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    if (flip_idx >= 0) f[14 + flip_idx] = f[14 + flip_idx] ^ 8'h01;
    return f;
  endfunction

  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    @(negedge clk);
    {rxd_hi, rxd_lo} = b;
    rx_dv = dv;
    rx_ctl_fall = dv ^ er;
  endtask

  task automatic send_frame(input bq_t fr, input int er_idx, input int rst_idx);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < fr.size(); i++) begin
      drive(fr[i], 1'b1, i == er_idx);
      if (rst_idx >= 0 && i == rst_idx) begin
        rst = 1'b0;
        #1;
        check("rst_strobes", {payload_valid, payload_data, payload_last, frame_done,
                              frame_ok, err_crc, err_len, err_phy}, '0);
        check("rst_header", {mac_dest, mac_src, ethertype}, '0);
      end
      if (rst_idx >= 0 && i == rst_idx + 3) rst = 1'b1;
    end
    for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int b_pv, b_done, mis;
    bq_t fr;

    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", {payload_valid, payload_data, payload_last, frame_done,
                            frame_ok, err_crc, err_len, err_phy}, '0);
    check("reset_header", {mac_dest, mac_src, ethertype}, '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) drive(8'h00, 1'b0, 1'b0);

    // 1: minimum-size frame to our address
    b_pv = pv_cnt; b_done = done_cnt;
    send_frame(mk_frame(MY_MAC, 46, -1), -1, -1);
    check("t1_pv_count", pv_cnt - b_pv, 46);
    mis = 0;
    for (int i = 0; i < 46; i++) if (pq[b_pv + i] !== 8'(i)) mis++;
    check("t1_data_mismatches", mis, 0);
    check("t1_done", done_cnt - b_done, 1);
    check("t1_last_with_done", d_last, 1);
    check("t1_last_data", d_last_data, 8'h2D);
    check("t1_ok", {d_ok, d_crc, d_len, d_phy}, 4'b1000);
    check("t1_mac_dest", mac_dest, MY_MAC);
    check("t1_mac_src", mac_src, SRC_MAC);
    check("t1_ethertype", ethertype, 16'h0800);

    // 2: corrupted payload byte
    b_pv = pv_cnt; b_done = done_cnt;
    send_frame(mk_frame(MY_MAC, 46, 10), -1, -1);
    check("t2_pv_count", pv_cnt - b_pv, 46);
    check("t2_done", done_cnt - b_done, 1);
    check("t2_flags", {d_ok, d_crc}, 2'b01);

    // 3: foreign address dropped, broadcast accepted
    b_pv = pv_cnt; b_done = done_cnt;
    send_frame(mk_frame(48'h02_00_00_00_00_99, 46, -1), -1, -1);
    check("t3_foreign_pv", pv_cnt - b_pv, 0);
    check("t3_foreign_done", done_cnt - b_done, 0);
    b_pv = pv_cnt; b_done = done_cnt;
    send_frame(mk_frame(BCAST, 50, -1), -1, -1);
    check("t3_bcast_done", done_cnt - b_done, 1);
    check("t3_bcast_ok", d_ok, 1);
    check("t3_bcast_pv", pv_cnt - b_pv, 50);
    check("t3_bcast_dest", mac_dest, BCAST);

    // 4: runt and oversize
    b_done = done_cnt;
    send_frame(mk_frame(MY_MAC, 22, -1), -1, -1);
    check("t4_runt_done", done_cnt - b_done, 1);
    check("t4_runt_flags", {d_ok, d_crc, d_len}, 3'b001);
    b_pv = pv_cnt; b_done = done_cnt;
    send_frame(mk_frame(MY_MAC, 1501, -1), -1, -1);
    check("t4_big_done", done_cnt - b_done, 1);
    check("t4_big_flags", {d_ok, d_len}, 2'b01);
    check("t4_big_pv_le_1500", (pv_cnt - b_pv) <= 1500, 1);

    // 5: RX_ER mid-payload
    b_done = done_cnt;
    send_frame(mk_frame(MY_MAC, 46, -1), 20, -1);
    check("t5_done", done_cnt - b_done, 1);
    check("t5_flags", {d_ok, d_crc, d_phy}, 3'b001);

    // 6: reset mid-payload, then a clean frame
    b_done = done_cnt;
    send_frame(mk_frame(MY_MAC, 46, -1), -1, 30);
    check("t6_cut_done", done_cnt - b_done, 0);
    b_pv = pv_cnt; b_done = done_cnt;
    send_frame(mk_frame(MY_MAC, 46, -1), -1, -1);
    check("t6_next_done", done_cnt - b_done, 1);
    check("t6_next_ok", d_ok, 1);
    check("t6_next_pv", pv_cnt - b_pv, 46);

    check("stray_last", last_stray, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
